bm_linked_list_mc: RTL and testbench
====================================

Name: bm_linked_list_mc

Overview:
- Buffer-manager link-list engine, next generation: parametrised pointer/length widths and buffer size.
- Holds the per-buffer next-pointer RAM written on enqueue.
- Serves packet dequeue next-pointer lookups at top priority.
- Runs NUM_RC_CH independent read-count walkers. Each walker expands one per-packet read-count request into one read_count update per buffer of the packet's chain.
- Adds per-channel request FIFOs with backpressure and round-robin walker arbitration.

Parameters:
- BUF_PTR_NBITS, 10, buffer pointer width; link RAM depth is 2**BUF_PTR_NBITS.
- PORT_ID_NBITS, 4, port id width.
- READ_COUNT_NBITS, 8, read count width.
- PACKET_LENGTH_NBITS, 14, packet length in bytes.
- BUF_SIZE, 128, bytes per buffer.
- NUM_RC_CH, 2, read-count channels (1..8).
- RC_FIFO_DEPTH, 8, entries per channel request FIFO (power of 2).

Ports:
- clk  in  1  single clock.
- `RESET_SIG  in  1  asynchronous active-low reset (codebase reset port name).
- enq_buf_valid  in  1  link write strobe.
- enq_buf_ptr_cur  in  BUF_PTR_NBITS  write address.
- enq_buf_ptr_nxt  in  BUF_PTR_NBITS  next pointer stored.
- packet_buf_req  in  1  dequeue lookup request.
- packet_buf_req_ptr  in  BUF_PTR_NBITS  pointer to look up.
- packet_ack_buf_valid  out  1  lookup result valid.
- packet_ack_buf_ptr  out  BUF_PTR_NBITS  next pointer.
- rc_req_valid  in  NUM_RC_CH  per-channel read-count request.
- rc_req_ready  out  NUM_RC_CH  per-channel FIFO not full.
- rc_req_buf_ptr  in  NUM_RC_CH*BUF_PTR_NBITS  first buffer of packet.
- rc_req_port_id  in  NUM_RC_CH*PORT_ID_NBITS  port id.
- rc_req_read_count  in  NUM_RC_CH*READ_COUNT_NBITS  count value.
- rc_req_packet_length  in  NUM_RC_CH*PACKET_LENGTH_NBITS  length.
- read_count_valid  out  1  per-buffer update.
- read_count_ch  out  clog2(NUM_RC_CH) (min 1)  source channel.
- read_count_port_id  out  PORT_ID_NBITS  port id of update.
- read_count_buf_ptr  out  BUF_PTR_NBITS  buffer of update.
- read_count  out  READ_COUNT_NBITS  count of update.
- inc_ll_wr_count  out  1  pulse per link write.
- inc_ll_rd_count  out  1  pulse per dequeue lookup.

Behaviour:
- Reset: all valid outputs 0; inc_* 0; rc_req_ready all 1; FIFOs empty; walkers IDLE; RR pointer 0. Data outputs are not reset.
- Link RAM: 1R1W, synchronous read, 1-cycle read latency. Write takes effect 1 cycle after enq_buf_valid (inputs registered). A same-cycle read and write to the same address returns the old data.
- Dequeue path: packet_buf_req at cycle T gives packet_ack_buf_valid at T+3 with RAM[ptr]. inc_ll_rd_count pulses at T+1. Back-to-back requests are fully pipelined. inc_ll_wr_count pulses 1 cycle after enq_buf_valid.
- Request FIFOs:
  - Push when rc_req_valid & rc_req_ready.
  - rc_req_ready = ~full.
  - A request with packet_length==0 is accepted but discarded (never pushed).
  - Push while full is impossible by handshake.
- Walker FSM per channel:
  - IDLE: on FIFO non-empty, pop and load ptr, port, count, and remaining = {1'b0,len}. Go to WALK.
  - WALK: request a RAM slot. When granted with ptr P, emit an update with buf_ptr P. Then remaining -= BUF_SIZE (width PACKET_LENGTH_NBITS+1).
    - If the pre-decrement remaining <= BUF_SIZE: last buffer; go to IDLE (may pop the next entry on the following cycle).
    - Otherwise go to WAIT.
  - WAIT: 1 cycle for RAM data. Load ptr = RAM dout, return to WALK.
  - Buffers emitted per packet = ceil(len/BUF_SIZE); len==BUF_SIZE gives exactly 1.
- Read-port arbitration per cycle:
  - Registered packet_buf_req has strict priority.
  - Otherwise, round-robin among channels in WALK; the RR pointer advances past the winner.
  - A preempted walker holds its state unchanged; no update is lost or duplicated.
- Output: at most one read_count_valid per cycle, registered, 1 cycle after grant. An update for a channel whose FIFO has just popped appears no earlier than 3 cycles after the push.
- A single channel with no dequeue traffic sustains 1 update per 2 cycles. Two or more channels sustain 1 per cycle.
- Reset mid-walk: walker state, FIFOs and pending updates are dropped. Link RAM contents are undefined afterwards.

Optional Feature:
- Macro BM_LL_PARITY_EN.
- When defined:
  - Link RAM is BUF_PTR_NBITS+1 wide, storing even parity of enq_buf_ptr_nxt.
  - Every read is checked.
  - New output ll_parity_err (1 bit) pulses 1 cycle after the RAM data is available on mismatch, for either a dequeue or a walker read.
  - Data still flows unchanged.
- When undefined: no extra RAM bit and no ll_parity_err port.

Decomposition:
- Shared package/defines.vh: BUF_PTR_NBITS, PORT_ID_NBITS, READ_COUNT_NBITS, PACKET_LENGTH_NBITS, BUF_SIZE defaults; walker state encoding (IDLE=0, WALK=1, WAIT=2); the rc request record layout {read_count, port_id, buf_ptr, packet_length}.
- Sub-module bm_ll_rc_walker: one instance per channel, holding FIFO (existing sfifo2f_fo) + FSM + remaining counter.
- Top level holds the arbiter, link RAM (ram_1r1w) and the dequeue pipeline.

Test Plan:
- Chain 5→9→3 written; packet_buf_req ptr 5 at T → ack at T+3 with ptr 9, inc_ll_rd_count at T+1.
- Ch0 len=300, BUF_SIZE=128, ptr 5, count 2, port 1 → updates on buffers 5, 9, 3 (count 2, port 1), 2 cycles apart; len=128 → single update; len=0 → none.
- Ch0 and ch1 both walking 3-buffer packets → updates alternate ch0/ch1 with valid every cycle, 6 total.
- packet_buf_req asserted every cycle for 4 cycles during a ch0 walk → no updates in those grant cycles; walk resumes with the correct next buffer, no duplicates.
- Push 8 requests to ch1 while the walker is stalled by dequeues → rc_req_ready[1]=0 after the 8th push; resumes to 1 after the first pop.
- BM_LL_PARITY_EN: force RAM parity-bit flip at ptr 9, dequeue ptr 9 → ll_parity_err one pulse, ack still delivered.

Source files
------------

// File: rtl/bm_linked_list_mc_pkg.sv
// bm_linked_list_mc_pkg: default widths, walker state encoding and a channel-index width helper
package bm_linked_list_mc_pkg;
    localparam int BUF_PTR_NBITS_DEF       = 10;
    localparam int PORT_ID_NBITS_DEF       = 4;
    localparam int READ_COUNT_NBITS_DEF    = 8;
    localparam int PACKET_LENGTH_NBITS_DEF = 14;
    localparam int BUF_SIZE_DEF            = 128;
    localparam int NUM_RC_CH_DEF           = 2;
    localparam int RC_FIFO_DEPTH_DEF       = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WALK = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    function automatic int ch_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/bm_linked_list_mc_rc_walker.sv
// bm_ll_rc_walker: per-channel request FIFO plus a walker that turns one packet request
// into one read-count update per buffer by following the link RAM.
module bm_ll_rc_walker
    import bm_linked_list_mc_pkg::*;
#(
    parameter int BUF_PTR_NBITS       = BUF_PTR_NBITS_DEF,
    parameter int PORT_ID_NBITS       = PORT_ID_NBITS_DEF,
    parameter int READ_COUNT_NBITS    = READ_COUNT_NBITS_DEF,
    parameter int PACKET_LENGTH_NBITS = PACKET_LENGTH_NBITS_DEF,
    parameter int BUF_SIZE            = BUF_SIZE_DEF,
    parameter int RC_FIFO_DEPTH       = RC_FIFO_DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [BUF_PTR_NBITS-1:0]       req_buf_ptr,
    input  logic [PORT_ID_NBITS-1:0]       req_port_id,
    input  logic [READ_COUNT_NBITS-1:0]    req_read_count,
    input  logic [PACKET_LENGTH_NBITS-1:0] req_packet_length,
    output logic                           rd_req,
    input  logic                           rd_gnt,
    input  logic [BUF_PTR_NBITS-1:0]       ram_dout,
    output logic [BUF_PTR_NBITS-1:0]       buf_ptr,
    output logic [PORT_ID_NBITS-1:0]       port_id,
    output logic [READ_COUNT_NBITS-1:0]    read_count
);
    localparam int AW = $clog2(RC_FIFO_DEPTH);
    localparam int RW = PACKET_LENGTH_NBITS + 1;
    localparam logic [RW-1:0] BUF_SZ   = RW'(BUF_SIZE);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(RC_FIFO_DEPTH);

    typedef struct packed {
        logic [READ_COUNT_NBITS-1:0]    read_count;
        logic [PORT_ID_NBITS-1:0]       port_id;
        logic [BUF_PTR_NBITS-1:0]       buf_ptr;
        logic [PACKET_LENGTH_NBITS-1:0] packet_length;
    } rc_rec_t;

    rc_rec_t       fifo [RC_FIFO_DEPTH];
    rc_rec_t       head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [RW-1:0] remaining;
    logic          push;
    logic          pop;
    logic          last;

    // zero-length packets own no buffers, so they are acknowledged but never queued
    assign req_ready = cnt != FULL_CNT;
    assign push      = req_valid & req_ready & (|req_packet_length);
    assign pop       = (state == ST_IDLE) & (cnt != '0);
    assign head      = fifo[rd_ptr];
    assign rd_req    = state == ST_WALK;
    assign last      = remaining <= BUF_SZ;

    always_comb
        state_nxt = (state == ST_IDLE) ? (pop ? ST_WALK : ST_IDLE) :
                    (state == ST_WALK) ? (rd_gnt ? (last ? ST_IDLE : ST_WAIT) : ST_WALK) :
                    ST_WALK;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= ST_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, push};
            rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, pop};
            cnt    <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end

    always_ff @(posedge clk)
        if (push) fifo[wr_ptr] <= {req_read_count, req_port_id, req_buf_ptr, req_packet_length};

    // WAIT sees the RAM word fetched on the grant cycle: that is the next buffer in the chain
    always_ff @(posedge clk)
        if (pop) begin
            buf_ptr    <= head.buf_ptr;
            port_id    <= head.port_id;
            read_count <= head.read_count;
            remaining  <= {1'b0, head.packet_length};
        end else if (rd_req && rd_gnt) begin
            remaining  <= remaining - BUF_SZ;
        end else if (state == ST_WAIT) begin
            buf_ptr    <= ram_dout;
        end
endmodule

// File: rtl/bm_linked_list_mc.sv
// bm_linked_list_mc: link RAM, dequeue next-pointer lookups and round-robin read-count walkers.
// Optional BM_LL_PARITY_EN adds an even-parity bit per link entry and the ll_parity_err output.
module bm_linked_list_mc
    import bm_linked_list_mc_pkg::*;
#(
    parameter int BUF_PTR_NBITS       = BUF_PTR_NBITS_DEF,
    parameter int PORT_ID_NBITS       = PORT_ID_NBITS_DEF,
    parameter int READ_COUNT_NBITS    = READ_COUNT_NBITS_DEF,
    parameter int PACKET_LENGTH_NBITS = PACKET_LENGTH_NBITS_DEF,
    parameter int BUF_SIZE            = BUF_SIZE_DEF,
    parameter int NUM_RC_CH           = NUM_RC_CH_DEF,
    parameter int RC_FIFO_DEPTH       = RC_FIFO_DEPTH_DEF
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     enq_buf_valid,
    input  logic [BUF_PTR_NBITS-1:0]                 enq_buf_ptr_cur,
    input  logic [BUF_PTR_NBITS-1:0]                 enq_buf_ptr_nxt,
    input  logic                                     packet_buf_req,
    input  logic [BUF_PTR_NBITS-1:0]                 packet_buf_req_ptr,
    output logic                                     packet_ack_buf_valid,
    output logic [BUF_PTR_NBITS-1:0]                 packet_ack_buf_ptr,
    input  logic [NUM_RC_CH-1:0]                     rc_req_valid,
    output logic [NUM_RC_CH-1:0]                     rc_req_ready,
    input  logic [NUM_RC_CH*BUF_PTR_NBITS-1:0]       rc_req_buf_ptr,
    input  logic [NUM_RC_CH*PORT_ID_NBITS-1:0]       rc_req_port_id,
    input  logic [NUM_RC_CH*READ_COUNT_NBITS-1:0]    rc_req_read_count,
    input  logic [NUM_RC_CH*PACKET_LENGTH_NBITS-1:0] rc_req_packet_length,
    output logic                                     read_count_valid,
    output logic [ch_bits(NUM_RC_CH)-1:0]            read_count_ch,
    output logic [PORT_ID_NBITS-1:0]                 read_count_port_id,
    output logic [BUF_PTR_NBITS-1:0]                 read_count_buf_ptr,
    output logic [READ_COUNT_NBITS-1:0]              read_count,
    output logic                                     inc_ll_wr_count,
    output logic                                     inc_ll_rd_count
`ifdef BM_LL_PARITY_EN
    ,output logic                                    ll_parity_err
`endif
);
    localparam int BP = BUF_PTR_NBITS;
    localparam int CW = ch_bits(NUM_RC_CH);
`ifdef BM_LL_PARITY_EN
    localparam int MW = BP + 1;
`else
    localparam int MW = BP;
`endif

    logic [MW-1:0]               mem [2**BP];
    logic [MW-1:0]               dout;
    logic [MW-1:0]               wr_data;
    logic [MW-1:0]               wr_data_q;
    logic [BP-1:0]               wr_addr_q;
    logic [BP-1:0]               req_ptr_q;
    logic [BP-1:0]               rd_addr;
    logic                        wr_q;
    logic                        req_q;
    logic                        rd_deq_q;
    logic [NUM_RC_CH-1:0]        walk_req;
    logic [NUM_RC_CH-1:0]        walk_gnt;
    logic [BP-1:0]               w_ptr  [NUM_RC_CH];
    logic [PORT_ID_NBITS-1:0]    w_port [NUM_RC_CH];
    logic [READ_COUNT_NBITS-1:0] w_cnt  [NUM_RC_CH];
    logic [CW-1:0]               rr;
    logic [CW-1:0]               rr_nxt;
    logic [CW-1:0]               win;
    logic                        win_vld;
    int                          j;

`ifdef BM_LL_PARITY_EN
    assign wr_data = {^enq_buf_ptr_nxt, enq_buf_ptr_nxt};
`else
    assign wr_data = enq_buf_ptr_nxt;
`endif

    assign inc_ll_wr_count = wr_q;
    assign inc_ll_rd_count = req_q;

    // scan downward so the requester closest after rr wins; dequeue lookups always preempt
    always_comb begin
        j       = 0;
        win     = rr;
        win_vld = 1'b0;
        for (int k = NUM_RC_CH - 1; k >= 0; k--) begin
            j = (int'(rr) + k) % NUM_RC_CH;
            if (walk_req[j]) begin
                win     = CW'(j);
                win_vld = 1'b1;
            end
        end
        walk_gnt = '0;
        if (win_vld && !req_q) walk_gnt[win] = 1'b1;
        rr_nxt  = (int'(win) == NUM_RC_CH - 1) ? '0 : win + 1'b1;
        rd_addr = req_q ? req_ptr_q : w_ptr[win];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_q                 <= 1'b0;
            req_q                <= 1'b0;
            rd_deq_q             <= 1'b0;
            packet_ack_buf_valid <= 1'b0;
            read_count_valid     <= 1'b0;
            rr                   <= '0;
        end else begin
            wr_q                 <= enq_buf_valid;
            req_q                <= packet_buf_req;
            rd_deq_q             <= req_q;
            packet_ack_buf_valid <= rd_deq_q;
            read_count_valid     <= |walk_gnt;
            if (|walk_gnt) rr <= rr_nxt;
        end

    always_ff @(posedge clk) begin
        wr_addr_q          <= enq_buf_ptr_cur;
        wr_data_q          <= wr_data;
        req_ptr_q          <= packet_buf_req_ptr;
        packet_ack_buf_ptr <= dout[BP-1:0];
        if (|walk_gnt) begin
            read_count_ch      <= win;
            read_count_port_id <= w_port[win];
            read_count_buf_ptr <= w_ptr[win];
            read_count         <= w_cnt[win];
        end
    end

    // read-before-write: a colliding read returns the previous entry
    always_ff @(posedge clk) begin
        if (wr_q) mem[wr_addr_q] <= wr_data_q;
        dout <= mem[rd_addr];
    end

`ifdef BM_LL_PARITY_EN
    logic rd_any_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_any_q      <= 1'b0;
            ll_parity_err <= 1'b0;
        end else begin
            rd_any_q      <= req_q | win_vld;
            ll_parity_err <= rd_any_q & (^dout);
        end
`endif

    for (genvar c = 0; c < NUM_RC_CH; c++) begin : g_ch
        bm_ll_rc_walker #(
            .BUF_PTR_NBITS      (BUF_PTR_NBITS),
            .PORT_ID_NBITS      (PORT_ID_NBITS),
            .READ_COUNT_NBITS   (READ_COUNT_NBITS),
            .PACKET_LENGTH_NBITS(PACKET_LENGTH_NBITS),
            .BUF_SIZE           (BUF_SIZE),
            .RC_FIFO_DEPTH      (RC_FIFO_DEPTH)
        ) u_walker (
            .clk              (clk),
            .rst_n            (rst_n),
            .req_valid        (rc_req_valid[c]),
            .req_ready        (rc_req_ready[c]),
            .req_buf_ptr      (rc_req_buf_ptr[c*BP +: BP]),
            .req_port_id      (rc_req_port_id[c*PORT_ID_NBITS +: PORT_ID_NBITS]),
            .req_read_count   (rc_req_read_count[c*READ_COUNT_NBITS +: READ_COUNT_NBITS]),
            .req_packet_length(rc_req_packet_length[c*PACKET_LENGTH_NBITS +: PACKET_LENGTH_NBITS]),
            .rd_req           (walk_req[c]),
            .rd_gnt           (walk_gnt[c]),
            .ram_dout         (dout[BP-1:0]),
            .buf_ptr          (w_ptr[c]),
            .port_id          (w_port[c]),
            .read_count       (w_cnt[c])
        );
    end
endmodule

// File: tb/tb_bm_linked_list_mc.sv
// tb_bm_linked_list_mc: scoreboard bench; a link-table model predicts lookups and per-buffer updates
module tb_bm_linked_list_mc;
    localparam int BP = 10, PW = 4, CNW = 8, LW = 14, BS = 128, NC = 2, FD = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enq_buf_valid = 1'b0;
    logic [BP-1:0]   enq_buf_ptr_cur = '0;
    logic [BP-1:0]   enq_buf_ptr_nxt = '0;
    logic            packet_buf_req = 1'b0;
    logic [BP-1:0]   packet_buf_req_ptr = '0;
    logic            packet_ack_buf_valid;
    logic [BP-1:0]   packet_ack_buf_ptr;
    logic [NC-1:0]   rc_req_valid = '0;
    logic [NC-1:0]   rc_req_ready;
    logic [NC*BP-1:0]  rc_req_buf_ptr = '0;
    logic [NC*PW-1:0]  rc_req_port_id = '0;
    logic [NC*CNW-1:0] rc_req_read_count = '0;
    logic [NC*LW-1:0]  rc_req_packet_length = '0;
    logic            read_count_valid;
    logic [0:0]      read_count_ch;
    logic [PW-1:0]   read_count_port_id;
    logic [BP-1:0]   read_count_buf_ptr;
    logic [CNW-1:0]  read_count;
    logic            inc_ll_wr_count;
    logic            inc_ll_rd_count;
`ifdef BM_LL_PARITY_EN
    logic            ll_parity_err;
`endif

    always #5 clk = ~clk;

    bm_linked_list_mc #(
        .BUF_PTR_NBITS(BP), .PORT_ID_NBITS(PW), .READ_COUNT_NBITS(CNW),
        .PACKET_LENGTH_NBITS(LW), .BUF_SIZE(BS), .NUM_RC_CH(NC), .RC_FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .enq_buf_valid(enq_buf_valid), .enq_buf_ptr_cur(enq_buf_ptr_cur), .enq_buf_ptr_nxt(enq_buf_ptr_nxt),
        .packet_buf_req(packet_buf_req), .packet_buf_req_ptr(packet_buf_req_ptr),
        .packet_ack_buf_valid(packet_ack_buf_valid), .packet_ack_buf_ptr(packet_ack_buf_ptr),
        .rc_req_valid(rc_req_valid), .rc_req_ready(rc_req_ready),
        .rc_req_buf_ptr(rc_req_buf_ptr), .rc_req_port_id(rc_req_port_id),
        .rc_req_read_count(rc_req_read_count), .rc_req_packet_length(rc_req_packet_length),
        .read_count_valid(read_count_valid), .read_count_ch(read_count_ch),
        .read_count_port_id(read_count_port_id), .read_count_buf_ptr(read_count_buf_ptr),
        .read_count(read_count), .inc_ll_wr_count(inc_ll_wr_count), .inc_ll_rd_count(inc_ll_rd_count)
`ifdef BM_LL_PARITY_EN
        , .ll_parity_err(ll_parity_err)
`endif
    );

    typedef struct {int c; int ptr;} ack_t;
    typedef struct {int ptr; int port; int cnt;} upd_t;
    typedef struct {int c; int ch;} log_t;

    int   total = 0, bad = 0, cyc = 0;
    int   link [1 << BP];
    ack_t ackq [$];
    upd_t rcq [NC][$];
    log_t ulog [$];
    bit   exp_rd [int];
    bit   exp_wr [int];
    bit   blk [int];
    bit   exp_perr [int];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // monitor: everything the DUT presents is compared against what the stimulus side queued
    always @(negedge clk) begin : mon
        ack_t a;
        upd_t u;
        if (rst_n) begin
            chk("inc_ll_rd_count", int'(inc_ll_rd_count), int'(exp_rd.exists(cyc)));
            chk("inc_ll_wr_count", int'(inc_ll_wr_count), int'(exp_wr.exists(cyc)));
`ifdef BM_LL_PARITY_EN
            chk("ll_parity_err", int'(ll_parity_err), int'(exp_perr.exists(cyc)));
`endif
            if (packet_ack_buf_valid) begin
                chk("ack_pending", int'(ackq.size() > 0), 1);
                if (ackq.size() > 0) begin
                    a = ackq.pop_front();
                    chk("ack_cycle", cyc, a.c);
                    chk("ack_ptr", int'(packet_ack_buf_ptr), a.ptr);
                end
            end
            if (read_count_valid) begin
                ulog.push_back('{cyc, int'(read_count_ch)});
                chk("update_in_dequeue_slot", int'(blk.exists(cyc)), 0);
                chk("update_pending", int'(rcq[read_count_ch].size() > 0), 1);
                if (rcq[read_count_ch].size() > 0) begin
                    u = rcq[read_count_ch].pop_front();
                    chk("upd_buf_ptr", int'(read_count_buf_ptr), u.ptr);
                    chk("upd_port_id", int'(read_count_port_id), u.port);
                    chk("upd_read_count", int'(read_count), u.cnt);
                end
            end
        end
    end

    task automatic expand(input int ch);
        int p, n, port, cnt;
        p    = int'(rc_req_buf_ptr[ch*BP +: BP]);
        port = int'(rc_req_port_id[ch*PW +: PW]);
        cnt  = int'(rc_req_read_count[ch*CNW +: CNW]);
        n    = (int'(rc_req_packet_length[ch*LW +: LW]) + BS - 1) / BS;
        for (int k = 0; k < n; k++) begin
            rcq[ch].push_back('{p, port, cnt});
            p = link[p];
        end
    endtask

    // record what the current inputs should cause, then advance one clock
    task automatic cycle();
        if (packet_buf_req) begin
            exp_rd[cyc + 1] = 1'b1;
            blk[cyc + 2]    = 1'b1;
            ackq.push_back('{cyc + 3, link[packet_buf_req_ptr]});
        end
        if (enq_buf_valid) begin
            exp_wr[cyc + 1] = 1'b1;
            link[enq_buf_ptr_cur] = int'(enq_buf_ptr_nxt);
        end
        for (int ch = 0; ch < NC; ch++)
            if (rc_req_valid[ch] && rc_req_ready[ch]) expand(ch);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_rc(input int ch, input int ptr, input int port, input int cnt, input int len);
        rc_req_valid[ch] = 1'b1;
        rc_req_buf_ptr[ch*BP +: BP]         = BP'(ptr);
        rc_req_port_id[ch*PW +: PW]         = PW'(port);
        rc_req_read_count[ch*CNW +: CNW]    = CNW'(cnt);
        rc_req_packet_length[ch*LW +: LW]   = LW'(len);
    endtask

    task automatic enq(input int cur, input int nxt);
        enq_buf_valid   = 1'b1;
        enq_buf_ptr_cur = BP'(cur);
        enq_buf_ptr_nxt = BP'(nxt);
        cycle();
        enq_buf_valid   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack_valid", int'(packet_ack_buf_valid), 0);
        chk("rst_rc_valid", int'(read_count_valid), 0);
        chk("rst_inc_wr", int'(inc_ll_wr_count), 0);
        chk("rst_inc_rd", int'(inc_ll_rd_count), 0);
        chk("rst_rc_ready", int'(rc_req_ready), (1 << NC) - 1);
        rst_n = 1'b1;
        cycle();

        for (int i = 0; i < (1 << BP); i++) enq(i, int'($urandom_range((1 << BP) - 1)));
        enq(5, 9);
        enq(9, 3);
        enq(3, 7);
        idle(2);

        packet_buf_req     = 1'b1;
        packet_buf_req_ptr = BP'(5);
        cycle();
        packet_buf_req     = 1'b0;
        idle(6);

        // single channel: 300 bytes -> three buffers, one update every other cycle
        ulog.delete();
        t0 = cyc;
        set_rc(0, 5, 1, 2, 300);
        cycle();
        rc_req_valid = '0;
        idle(12);
        chk("single_ch_count", ulog.size(), 3);
        for (int k = 0; k < ulog.size(); k++) chk("single_ch_timing", ulog[k].c, t0 + 3 + 2 * k);

        ulog.delete();
        set_rc(0, 9, 2, 5, 128);
        cycle();
        rc_req_valid = '0;
        idle(8);
        chk("len_eq_buf_size_count", ulog.size(), 1);

        ulog.delete();
        set_rc(0, 9, 2, 5, 0);
        cycle();
        rc_req_valid = '0;
        idle(8);
        chk("len_zero_count", ulog.size(), 0);

        // two channels: updates every cycle, alternating source
        ulog.delete();
        t0 = cyc;
        set_rc(0, int'($urandom_range(1023)), 6, 11, 300);
        set_rc(1, int'($urandom_range(1023)), 7, 12, 333);
        cycle();
        rc_req_valid = '0;
        idle(14);
        chk("two_ch_count", ulog.size(), 6);
        for (int k = 0; k < ulog.size(); k++) chk("two_ch_timing", ulog[k].c, t0 + 3 + k);
        for (int k = 1; k < ulog.size(); k++) chk("two_ch_alternate", int'(ulog[k].ch != ulog[k-1].ch), 1);

        // dequeue burst preempting a walk
        ulog.delete();
        set_rc(0, 5, 3, 4, 640);
        cycle();
        rc_req_valid = '0;
        idle(2);
        packet_buf_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            packet_buf_req_ptr = BP'($urandom_range(1023));
            cycle();
        end
        packet_buf_req = 1'b0;
        idle(20);
        chk("preempt_count", ulog.size(), 5);

        // backpressure: walker starved by dequeues, one packet held plus FD queued
        packet_buf_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            packet_buf_req_ptr = BP'($urandom_range(1023));
            cycle();
        end
        for (int i = 0; i < FD + 1; i++) begin
            chk("ready_before_push", int'(rc_req_ready[1]), 1);
            set_rc(1, int'($urandom_range(1023)), int'($urandom_range(15)), int'($urandom_range(255)), 300);
            packet_buf_req_ptr = BP'($urandom_range(1023));
            cycle();
        end
        rc_req_valid = '0;
        chk("ready_full", int'(rc_req_ready[1]), 0);
        for (int i = 0; i < 3; i++) begin
            packet_buf_req_ptr = BP'($urandom_range(1023));
            cycle();
        end
        chk("ready_full_held", int'(rc_req_ready[1]), 0);
        packet_buf_req = 1'b0;
        n = 0;
        while (!rc_req_ready[1] && n < 30) begin
            cycle();
            n++;
        end
        chk("ready_recovers", int'(rc_req_ready[1]), 1);
        idle(80);

`ifdef BM_LL_PARITY_EN
        dut.mem[9][BP] = ~dut.mem[9][BP];
        exp_perr[cyc + 3] = 1'b1;
        packet_buf_req     = 1'b1;
        packet_buf_req_ptr = BP'(9);
        cycle();
        packet_buf_req = 1'b0;
        idle(6);
        dut.mem[9][BP] = ~dut.mem[9][BP];
`endif

        // random mix of dequeues and read-count requests on both channels
        for (int i = 0; i < 400; i++) begin
            packet_buf_req     = ($urandom_range(3) == 0);
            packet_buf_req_ptr = BP'($urandom_range(1023));
            for (int ch = 0; ch < NC; ch++)
                if ($urandom_range(9) < 3)
                    set_rc(ch, int'($urandom_range(1023)), int'($urandom_range(15)),
                           int'($urandom_range(255)), int'($urandom_range(1100)));
                else
                    rc_req_valid[ch] = 1'b0;
            cycle();
        end
        packet_buf_req = 1'b0;
        rc_req_valid   = '0;
        n = 0;
        while ((ackq.size() > 0 || rcq[0].size() > 0 || rcq[1].size() > 0) && n < 4000) begin
            cycle();
            n++;
        end
        idle(4);
        chk("ack_queue_drained", ackq.size(), 0);
        for (int ch = 0; ch < NC; ch++) chk("rc_queue_drained", rcq[ch].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
